// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared types and constants for the ballot sequencer and voter-ID database
// Contents: session state enum, reject-code constants, default database widths.
package evm_pkg;

    // Defaults shared with the voter-ID database block so both sides agree on widths.
    localparam int EVM_WORD_SIZE    = 5;
    localparam int EVM_ADDRESS_SIZE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_VOTE,
        ST_COMMIT,
        ST_REJECT
    } evm_state_e;

    localparam logic [1:0] RC_NONE    = 2'd0;
    localparam logic [1:0] RC_ILLEGAL = 2'd1;
    localparam logic [1:0] RC_DUP     = 2'd2;
    localparam logic [1:0] RC_FULL    = 2'd3;

endpackage

// File: rtl/evm_onehot_decode.sv
// rtl/evm_onehot_decode.sv - one-hot button vector to valid flag plus binary index
// Ports:
//   onehot  in   N      button vector
//   valid   out  1      exactly one bit set
//   idx     out  IDX_W  position of the set bit (meaningful only when valid)
// Purely combinational; also usable by the tally display to select a counter.
module evm_onehot_decode #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     onehot,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
        valid = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/evm_vote_sequencer.sv
// rtl/evm_vote_sequencer.sv - ballot-session controller in front of the voter-ID database
// Optional feature macro: EVM_VOTE_TIMEOUT_EN (VOTE-state timeout after TIMEOUT_CYCLES).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mode, id_valid, voter_id        voting mode, ID strobe and ID
//   cand_btn                        candidate buttons (one-hot to be accepted)
//   db_status                       registered lookup result from the database
//   db_mode/control/read/write      database strobes, forced low while reset is high
//   db_voter_id                     lookup ID
//   db_valid_voter(_address)        write data and address
//   busy, vote_accepted, vote_rejected, reject_code, db_full, cand_counts  status
module evm_vote_sequencer
    import evm_pkg::*;
#(
    parameter int WORD_SIZE    = EVM_WORD_SIZE,
    parameter int ADDRESS_SIZE = EVM_ADDRESS_SIZE,
    parameter int NUM_CAND     = 4,
    parameter int COUNT_W      = 8
`ifdef EVM_VOTE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        id_valid,
    input  logic [WORD_SIZE-1:0]        voter_id,
    input  logic [NUM_CAND-1:0]         cand_btn,
    input  logic                        db_status,
    output logic                        db_mode,
    output logic                        db_control,
    output logic                        db_read,
    output logic                        db_write,
    output logic [WORD_SIZE-1:0]        db_voter_id,
    output logic [WORD_SIZE-1:0]        db_valid_voter,
    output logic [ADDRESS_SIZE-1:0]     db_valid_voter_address,
    output logic                        busy,
    output logic                        vote_accepted,
    output logic                        vote_rejected,
    output logic [1:0]                  reject_code,
    output logic                        db_full,
    output logic [NUM_CAND*COUNT_W-1:0] cand_counts
);

    localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    // Entry 2**ADDRESS_SIZE-1 is never used, so "full" is the all-ones pointer.
    localparam logic [ADDRESS_SIZE-1:0] MAX_ENTRIES = '1;

    evm_state_e                         state_q, state_d;
    logic [WORD_SIZE-1:0]               id_q, id_d;
    logic [1:0]                         rc_q, rc_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [ADDRESS_SIZE-1:0]            ptr_q, ptr_d;
    logic [NUM_CAND-1:0][COUNT_W-1:0]   counts_q, counts_d;

`ifdef EVM_VOTE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    logic             btn_valid;
    logic [IDX_W-1:0] btn_idx;
    logic             full_w;

    evm_onehot_decode #(
        .N     (NUM_CAND),
        .IDX_W (IDX_W)
    ) u_btn_decode (
        .onehot (cand_btn),
        .valid  (btn_valid),
        .idx    (btn_idx)
    );

    assign full_w = (ptr_q == MAX_ENTRIES);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rc_d     = rc_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        counts_d = counts_q;
`ifdef EVM_VOTE_TIMEOUT_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mode && id_valid) begin
                    id_d = voter_id;
                    // Cleared database entries read as 0, so ID 0 would always false-match.
                    if (voter_id == '0) begin
                        state_d = ST_REJECT;
                        rc_d    = RC_ILLEGAL;
                    end else if (full_w) begin
                        state_d = ST_REJECT;
                        rc_d    = RC_FULL;
                    end else begin
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = mode ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                if (!mode) begin
                    state_d = ST_IDLE;
                end else if (db_status) begin
                    state_d = ST_REJECT;
                    rc_d    = RC_DUP;
                end else begin
                    state_d = ST_VOTE;
`ifdef EVM_VOTE_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_VOTE: begin
                if (!mode) begin
                    state_d = ST_IDLE;
                end else if (btn_valid) begin
                    idx_d   = btn_idx;
                    rc_d    = RC_NONE;
                    state_d = ST_COMMIT;
`ifdef EVM_VOTE_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_REJECT;
                    rc_d    = RC_FULL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
`endif
                end
            end
            ST_COMMIT: begin
                if (counts_q[idx_q] != '1) begin
                    counts_d[idx_q] = counts_q[idx_q] + COUNT_W'(1);
                end
                ptr_d   = ptr_q + ADDRESS_SIZE'(1);
                state_d = ST_IDLE;
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            rc_q     <= RC_NONE;
            idx_q    <= '0;
            ptr_q    <= '0;
            counts_q <= '0;
`ifdef EVM_VOTE_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rc_q     <= rc_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            counts_q <= counts_d;
`ifdef EVM_VOTE_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // The database lets a write win over its own reset, so every strobe is gated by reset.
    assign db_mode       = ~reset & ((state_q == ST_LOOKUP) | (state_q == ST_COMMIT));
    assign db_control    = db_mode;
    assign db_read       = ~reset & (state_q == ST_LOOKUP);
    assign db_write      = ~reset & (state_q == ST_COMMIT);
    assign vote_accepted = ~reset & (state_q == ST_COMMIT);
    assign vote_rejected = ~reset & (state_q == ST_REJECT);

    assign db_voter_id            = id_q;
    assign db_valid_voter         = id_q;
    assign db_valid_voter_address = ptr_q;
    assign busy                   = (state_q != ST_IDLE);
    assign reject_code            = rc_q;
    assign db_full                = full_w;
    assign cand_counts            = counts_q;

endmodule
